mag_countdown_timer: RTL and testbench
======================================

# mag_countdown_timer

BCD minutes:seconds countdown timer for the microwave controller. Captures cook time from keypad digits, counts down once per second while the magnetron is enabled, and drives `timer_done` into the magnetron control stage, where it forces the magnetron latch reset. It sits directly upstream of `control_mag` and consumes the magnetron-on status as its count enable.

## Interface
- `TICKS_PER_SEC`, default 100: clock cycles per one-second decrement. Use 100 in simulation and the board clock rate in synthesis. Minimum 2.
- `clk` input 1: system clock, rising-edge active.
- `resetn` input 1: asynchronous, active-low reset.
- `clearn` input 1: synchronous, active-low clear of the time value to 00:00.
- `enable` input 1: magnetron-on status; counting is allowed only while this is high.
- `digit_valid` input 1: one-cycle strobe that presents a keypad digit.
- `digit_in` input 4: keypad digit in BCD. Values above 9 are ignored.
- `add30` input 1: one-cycle strobe that adds 30 s (see Configuration).
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: current time in BCD, registered.
- `timer_done` output 1: high when the time is 00:00, registered.

## Operation
- Internal state is four BCD digit registers plus a prescaler counter of width `$clog2(TICKS_PER_SEC)`.
- Phases are derived from the state:
  - IDLE: time = 00:00.
  - ARMED: time ≠ 0 and `enable` = 0.
  - RUN: time ≠ 0 and `enable` = 1.
- Priority per clock cycle, highest first:
  1. `clearn` = 0: all digits go to 0 and the prescaler goes to 0.
  2. Decrement tick, in RUN only.
  3. `add30`.
  4. Digit entry.
- Digit entry:
  - Accepted only when `enable` = 0, `digit_valid` = 1 and `digit_in` ≤ 9.
  - The value shifts left one digit: `min_tens` ← `min_ones`, `min_ones` ← `sec_tens`, `sec_tens` ← `sec_ones`, `sec_ones` ← `digit_in`.
  - The old `min_tens` is discarded.
- Prescaler:
  - Held at 0 whenever `enable` = 0 or time = 0.
  - In RUN it increments each cycle. When it reaches `TICKS_PER_SEC-1` it wraps to 0 and generates the decrement tick.
- Decrement rules, BCD:
  - If `sec_ones` > 0: decrement `sec_ones`.
  - Else if `sec_tens` > 0: decrement `sec_tens` and set `sec_ones` to 9.
  - Else, borrow from minutes: set seconds to 59 and decrement `min_ones`. If `min_ones` = 0, set `min_ones` to 9 and decrement `min_tens`.
  - Seconds entered above 59 (for example 01:90) are legal and count down through 90, 89, ... without normalisation.
- Time never decrements below 00:00. The prescaler stops once the time reaches 0.
- While `enable` = 1, digit entry is ignored.
- Dropping `enable` pauses the count and keeps the time. The partial-second prescaler count is discarded.

## Timing
- Reset values: all digits 0, prescaler 0, `timer_done` = 1. The "done" indication is the safe state for the magnetron.
- `timer_done` is registered from the next-state time. It rises on the same clock edge at which the digits become 00:00, and falls on the same edge at which a nonzero value is loaded.
- Digit entry: the new value appears on the outputs on the first edge after `digit_valid` is sampled high (one-cycle latency).
- First decrement: `TICKS_PER_SEC` cycles after the first RUN cycle. Subsequent decrements occur every `TICKS_PER_SEC` cycles.
- Tick and `enable` falling in the same cycle: the tick takes effect only if `enable` was sampled high on that edge.
- Tick and `clearn` = 0 in the same cycle: clear wins.
- Tick coinciding with `add30` or `digit_valid`: the tick wins and the other strobe is dropped.
- `resetn` asserted mid-count: all outputs return to their reset values immediately (asynchronously), regardless of `clk`.

## Configuration
- Macro: `MAG_TIMER_ADD30_EN`.
- Defined:
  - Each accepted `add30` strobe adds 30 s with BCD carry; seconds carry into minutes when the sum is ≥ 60.
  - The result saturates at 99:59.
  - `add30` is accepted in IDLE, ARMED and RUN.
  - In RUN, the prescaler is not disturbed by `add30`.
- Undefined: the `add30` port exists but is ignored, and the time is unchanged.

## Test plan
- **Reset:** `resetn` = 0 mid-RUN at 01:23 → digits 0000 and `timer_done` = 1 at once, with no `clk` edge needed.
- **Entry:** digits 1, 2, 3, 4 entered with `enable` = 0 → outputs 12:34 and `timer_done` = 0; then digit 11 → unchanged; then digit 5 → 23:45.
- **Countdown with borrow:** load 01:00, `enable` = 1, `TICKS_PER_SEC` = 100 → 00:59 at cycle 100 and 00:58 at cycle 200; `timer_done` rises exactly at cycle 6000 and the time holds at 00:00.
- **Pause:** in RUN at 00:10, drop `enable` for 250 cycles, then raise it → still 00:10 during the pause; 00:09 arrives 100 cycles after re-enable; `digit_valid` during RUN has no effect.
- **Clear priority:** `clearn` = 0 on the same cycle as a tick at 00:05 → 00:00 and `timer_done` = 1.
- **Add30 (with `MAG_TIMER_ADD30_EN`):**
  - 00:45 + `add30` → 01:15.
  - 99:40 + `add30` → 99:59.
  - Without the macro, 00:45 stays 00:45.

Source files
------------

// File: rtl/mag_countdown_timer.sv
// -----------------------------------------------------------------------------
// mag_countdown_timer
//
// BCD minutes:seconds countdown timer for the microwave controller. Cook time
// is keyed in digit by digit. The timer counts down once per second while the
// magnetron is on. It drives timer_done, which the downstream control_mag
// stage uses to force its magnetron latch into reset.
//
// Build option:
//   MAG_TIMER_ADD30_EN - when defined, each add30 strobe adds 30 s with BCD
//                        carry, saturating at 99:59. When undefined, add30 is
//                        ignored.
//
// Parameters:
//   TICKS_PER_SEC - clock cycles per one-second decrement (minimum 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   clearn       in   synchronous active-low clear to 00:00
//   enable       in   magnetron-on status, the count enable
//   digit_valid  in   one-cycle strobe qualifying digit_in
//   digit_in     in   [3:0] keypad digit in BCD (values above 9 are ignored)
//   add30        in   one-cycle strobe: add 30 s
//   min_tens     out  [3:0] registered BCD minutes tens
//   min_ones     out  [3:0] registered BCD minutes ones
//   sec_tens     out  [3:0] registered BCD seconds tens
//   sec_ones     out  [3:0] registered BCD seconds ones
//   timer_done   out  registered, high while the time is 00:00
//
// Strobe semantics: digit_valid and add30 are sampled on every rising edge
// they are high. There is no ready/backpressure, so a strobe that loses to a
// higher-priority event on that edge is dropped, not held. The priority, from
// highest to lowest, is: clear, then the decrement tick, then add30, then
// digit entry.
//
// Phases are derived from the state rather than stored:
//   IDLE  = time is 00:00
//   ARMED = time is nonzero and enable is low
//   RUN   = time is nonzero and enable is high
// -----------------------------------------------------------------------------
module mag_countdown_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       enable,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    input  logic       add30,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic [3:0]    mt_n, mo_n, st_n, so_n;
    logic          time_zero;
    logic          run;
    logic          tick;
    logic          digit_ok;

    assign time_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign run       = enable && !time_zero;
    assign tick      = run && (presc == PRESC_LAST);
    assign digit_ok  = !enable && digit_valid && (digit_in <= 4'd9);

`ifdef MAG_TIMER_ADD30_EN
    // Add 30 s. Seconds above 59 are legal input, so the seconds-tens sum
    // can reach 12. Anything at or above 6 carries one minute.
    logic [4:0] st_sum;
    logic [4:0] mo_sum;
    logic [4:0] mt_sum;
    logic       sec_carry;
    logic       min_carry;
    logic [3:0] a30_mt, a30_mo, a30_st, a30_so;

    always_comb begin
        st_sum    = {1'b0, sec_tens} + 5'd3;
        sec_carry = (st_sum >= 5'd6);
        a30_st    = sec_carry ? 4'(st_sum - 5'd6) : st_sum[3:0];
        mo_sum    = {1'b0, min_ones} + {4'd0, sec_carry};
        min_carry = (mo_sum >= 5'd10);
        a30_mo    = min_carry ? 4'(mo_sum - 5'd10) : mo_sum[3:0];
        mt_sum    = {1'b0, min_tens} + {4'd0, min_carry};
        a30_mt    = mt_sum[3:0];
        a30_so    = sec_ones;
        if (mt_sum >= 5'd10) begin
            // Past 99 minutes: saturate at 99:59.
            a30_mt = 4'd9;
            a30_mo = 4'd9;
            a30_st = 4'd5;
            a30_so = 4'd9;
        end
    end
`else
    logic add30_unused;
    assign add30_unused = add30;
`endif

    always_comb begin
        mt_n    = min_tens;
        mo_n    = min_ones;
        st_n    = sec_tens;
        so_n    = sec_ones;
        presc_n = presc;
        if (!clearn) begin
            mt_n    = 4'd0;
            mo_n    = 4'd0;
            st_n    = 4'd0;
            so_n    = 4'd0;
            presc_n = '0;
        end else begin
            // The prescaler only runs in RUN. Leaving RUN discards any
            // partial second.
            if (!run) begin
                presc_n = '0;
            end else if (tick) begin
                presc_n = '0;
            end else begin
                presc_n = presc + 1'b1;
            end

            if (tick) begin
                if (sec_ones != 4'd0) begin
                    so_n = sec_ones - 4'd1;
                end else if (sec_tens != 4'd0) begin
                    st_n = sec_tens - 4'd1;
                    so_n = 4'd9;
                end else begin
                    st_n = 4'd5;
                    so_n = 4'd9;
                    if (min_ones != 4'd0) begin
                        mo_n = min_ones - 4'd1;
                    end else begin
                        // In RUN the time is nonzero, so min_tens > 0 here.
                        mo_n = 4'd9;
                        mt_n = min_tens - 4'd1;
                    end
                end
            end
`ifdef MAG_TIMER_ADD30_EN
            else if (add30) begin
                mt_n = a30_mt;
                mo_n = a30_mo;
                st_n = a30_st;
                so_n = a30_so;
            end
`endif
            else if (digit_ok) begin
                mt_n = min_ones;
                mo_n = sec_tens;
                st_n = sec_ones;
                so_n = digit_in;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            presc      <= '0;
            timer_done <= 1'b1;
        end else begin
            min_tens   <= mt_n;
            min_ones   <= mo_n;
            sec_tens   <= st_n;
            sec_ones   <= so_n;
            presc      <= presc_n;
            // Derived from next-state time so done tracks the digits on the
            // same edge.
            timer_done <= ({mt_n, mo_n, st_n, so_n} == 16'h0000);
        end
    end

endmodule

// File: tb/tb_mag_countdown_timer.sv
module tb_mag_countdown_timer;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       resetn;
    logic       clearn;
    logic       enable;
    logic       digit_valid;
    logic [3:0] digit_in;
    logic       add30;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;

    always #5 clk = ~clk;

    mag_countdown_timer #(.TICKS_PER_SEC(100)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .clearn      (clearn),
        .enable      (enable),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .add30       (add30),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .timer_done  (timer_done)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] exp_t, input logic exp_done);
        logic [15:0] act_t;
        act_t = {min_tens, min_ones, sec_tens, sec_ones};
        n_checks++;
        if (act_t !== exp_t || timer_done !== exp_done) begin
            n_fail++;
            $display("FAIL %s: got %04h done=%0b, expected %04h done=%0b",
                     name, act_t, timer_done, exp_t, exp_done);
        end
    endtask

    // Seconds (below 6000) to mm:ss BCD.
    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int sec;
        m   = s / 60;
        sec = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    // ---------------- drivers ----------------
    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic enter_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       clearn;
        logic       dv;
        logic [3:0] din;
        logic       add30;
        logic [15:0] exp_t;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] a30_45;
    logic [15:0] a30_9940;
    logic [15:0] a30_idle;
    logic        a30_idle_done;
    logic [15:0] a30_run;

    initial begin
`ifdef MAG_TIMER_ADD30_EN
        a30_45        = 16'h0115;
        a30_9940      = 16'h9959;
        a30_idle      = 16'h0030;
        a30_idle_done = 1'b0;
        a30_run       = 16'h0035;
`else
        a30_45        = 16'h0045;
        a30_9940      = 16'h9940;
        a30_idle      = 16'h0000;
        a30_idle_done = 1'b1;
        a30_run       = 16'h0005;
`endif
        //              name             clr  dv   din    a30   exp_t     done
        vecs.push_back('{"entry_1",      1'b1, 1'b1, 4'd1,  1'b0, 16'h0001, 1'b0});
        vecs.push_back('{"entry_2",      1'b1, 1'b1, 4'd2,  1'b0, 16'h0012, 1'b0});
        vecs.push_back('{"entry_3",      1'b1, 1'b1, 4'd3,  1'b0, 16'h0123, 1'b0});
        vecs.push_back('{"entry_4",      1'b1, 1'b1, 4'd4,  1'b0, 16'h1234, 1'b0});
        vecs.push_back('{"entry_11_ign", 1'b1, 1'b1, 4'd11, 1'b0, 16'h1234, 1'b0});
        vecs.push_back('{"entry_5",      1'b1, 1'b1, 4'd5,  1'b0, 16'h2345, 1'b0});
        vecs.push_back('{"no_strobe",    1'b1, 1'b0, 4'd7,  1'b0, 16'h2345, 1'b0});
        vecs.push_back('{"clear",        1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"entry_zero",   1'b1, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"clear_vs_dig", 1'b0, 1'b1, 4'd8,  1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"load_4",       1'b1, 1'b1, 4'd4,  1'b0, 16'h0004, 1'b0});
        vecs.push_back('{"load_5",       1'b1, 1'b1, 4'd5,  1'b0, 16'h0045, 1'b0});
        vecs.push_back('{"add30_0045",   1'b1, 1'b0, 4'd0,  1'b1, a30_45,   1'b0});
        vecs.push_back('{"clear2",       1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"add30_idle",   1'b1, 1'b0, 4'd0,  1'b1, a30_idle, a30_idle_done});
        vecs.push_back('{"clear3",       1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"load_9a",      1'b1, 1'b1, 4'd9,  1'b0, 16'h0009, 1'b0});
        vecs.push_back('{"load_9b",      1'b1, 1'b1, 4'd9,  1'b0, 16'h0099, 1'b0});
        vecs.push_back('{"load_4b",      1'b1, 1'b1, 4'd4,  1'b0, 16'h0994, 1'b0});
        vecs.push_back('{"load_0",       1'b1, 1'b1, 4'd0,  1'b0, 16'h9940, 1'b0});
        vecs.push_back('{"add30_sat",    1'b1, 1'b0, 4'd0,  1'b1, a30_9940, 1'b0});
        vecs.push_back('{"clear4",       1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b1});
    end

    // ---------------- test sequence ----------------
    initial begin
        resetn      = 1'b0;
        clearn      = 1'b1;
        enable      = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        add30       = 1'b0;
        steps(2);
        check("reset_state", 16'h0000, 1'b1);
        resetn = 1'b1;
        step();
        check("after_reset", 16'h0000, 1'b1);

        // Table: one cycle per vector, enable low throughout.
        foreach (vecs[i]) begin
            clearn      = vecs[i].clearn;
            digit_valid = vecs[i].dv;
            digit_in    = vecs[i].din;
            add30       = vecs[i].add30;
            exp_q.push_back({vecs[i].exp_t, vecs[i].exp_done});
            step();
            begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check(vecs[i].name, e[16:1], e[0]);
            end
        end
        clearn      = 1'b1;
        digit_valid = 1'b0;
        add30       = 1'b0;

        // Countdown with borrow from 01:00.
        do_clear();
        enter_digit(4'd1);
        enter_digit(4'd0);
        enter_digit(4'd0);
        check("load_0100", 16'h0100, 1'b0);
        enable = 1'b1;
        for (int i = 1; i <= 6000; i++) begin
            step();
            if (i % 100 == 0 || i % 100 == 99)
                check("countdown", to_bcd(60 - i / 100), (i == 6000));
        end
        steps(150);
        check("hold_at_zero", 16'h0000, 1'b1);
        enable = 1'b0;

        // Pause / resume from 00:10; digit entry ignored in RUN.
        do_clear();
        enter_digit(4'd1);
        enter_digit(4'd0);
        enable = 1'b1;
        steps(20);
        enter_digit(4'd7);
        steps(29);
        check("run_entry_ignored", 16'h0010, 1'b0);
        enable = 1'b0;
        steps(250);
        check("pause_hold", 16'h0010, 1'b0);
        enable = 1'b1;
        steps(99);
        check("pause_no_early_tick", 16'h0010, 1'b0);
        step();
        check("pause_resume_tick", 16'h0009, 1'b0);

        // add30 on the tick edge is dropped.
        steps(99);
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        check("tick_beats_add30", 16'h0008, 1'b0);

        // Clear on the tick edge wins.
        steps(300);
        check("run_to_0005", 16'h0005, 1'b0);
        steps(99);
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        check("clear_beats_tick", 16'h0000, 1'b1);
        enable = 1'b0;

        // add30 in RUN leaves the prescaler phase alone.
        enter_digit(4'd5);
        enable = 1'b1;
        steps(50);
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        check("add30_run", a30_run, 1'b0);
        steps(48);
        check("add30_run_hold", a30_run, 1'b0);
        step();
        check("add30_presc_kept", a30_run - 16'h0001, 1'b0);
        enable = 1'b0;

        // Asynchronous reset mid-count at 01:23.
        do_clear();
        enter_digit(4'd1);
        enter_digit(4'd2);
        enter_digit(4'd3);
        enable = 1'b1;
        steps(30);
        check("pre_async_reset", 16'h0123, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", 16'h0000, 1'b1);
        enable = 1'b0;
        step();
        resetn = 1'b1;
        step();
        check("after_async_reset", 16'h0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
